// File: rtl/camera_pixel_packer.sv
// ============================================================================
// camera_pixel_packer : DVP byte capture, window crop and 4-byte word packer
// Revision : 1.0
// ============================================================================
`default_nettype none

module camera_pixel_packer #(
    parameter int BUFF_LENGTH = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 12,
    parameter int H_START     = 0,
    parameter int H_WIDTH     = 1280,
    parameter int V_START     = 0,
    parameter int V_HEIGHT    = 480
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic                   vsync,
    input  logic                   href,
    input  logic [DATA_WIDTH-1:0]  cam_data,
    input  logic                   buff_ready,
    input  logic                   clr_status,
    output logic [BUFF_LENGTH-1:0] data_buffer,
    output logic                   buff_done,
    output logic                   frame_done,
    output logic [15:0]            word_cnt,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        FRAME     = 1'b1
    } state_t;

    // Window bounds are one bit wider than the counters so the end never wraps.
    localparam int H_END_I = H_START + H_WIDTH;
    localparam int V_END_I = V_START + V_HEIGHT;
    localparam int H_BEG_I = H_START;
    localparam int V_BEG_I = V_START;
    localparam logic [CNT_WIDTH:0] H_BEG = H_BEG_I[CNT_WIDTH:0];
    localparam logic [CNT_WIDTH:0] H_END = H_END_I[CNT_WIDTH:0];
    localparam logic [CNT_WIDTH:0] V_BEG = V_BEG_I[CNT_WIDTH:0];
    localparam logic [CNT_WIDTH:0] V_END = V_END_I[CNT_WIDTH:0];

    state_t                 state_q, state_d;
    logic                   vsync_q;
    logic                   href_q;
    logic [CNT_WIDTH-1:0]   col_q, col_d;
    logic [CNT_WIDTH-1:0]   row_q, row_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [BUFF_LENGTH-1:0] shift_q, shift_d;
    logic [BUFF_LENGTH-1:0] data_q, data_d;
    logic                   buff_done_q, buff_done_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            word_cnt_q, word_cnt_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic                   vsync_fall;
    logic                   vsync_rise;
    logic                   href_fall;
    logic [CNT_WIDTH:0]     col_ext;
    logic [CNT_WIDTH:0]     row_ext;
    logic                   h_lo_ok;
    logic                   v_lo_ok;
    logic                   in_window;
    logic [BUFF_LENGTH-1:0] shift_next;

    assign vsync_fall = vsync_q & ~vsync;
    assign vsync_rise = ~vsync_q & vsync;
    assign href_fall  = href_q & ~href;
    assign col_ext    = {1'b0, col_q};
    assign row_ext    = {1'b0, row_q};
    assign shift_next = {shift_q[BUFF_LENGTH-DATA_WIDTH-1:0], cam_data};

    // A zero start bound would make the lower compare constant-true.
    generate
        if (H_START == 0) begin : g_h_lo_zero
            assign h_lo_ok = 1'b1;
        end else begin : g_h_lo_cmp
            assign h_lo_ok = (col_ext >= H_BEG);
        end
        if (V_START == 0) begin : g_v_lo_zero
            assign v_lo_ok = 1'b1;
        end else begin : g_v_lo_cmp
            assign v_lo_ok = (row_ext >= V_BEG);
        end
    endgenerate

    assign in_window = h_lo_ok && (col_ext < H_END) && v_lo_ok && (row_ext < V_END);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_SYNC;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            byte_idx_q   <= 2'd0;
            shift_q      <= '0;
            data_q       <= '0;
            buff_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            word_cnt_q   <= 16'd0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            href_q       <= href;
            col_q        <= col_d;
            row_q        <= row_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            buff_done_q  <= buff_done_d;
            frame_done_q <= frame_done_d;
            word_cnt_q   <= word_cnt_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        buff_done_d  = 1'b0;
        frame_done_d = 1'b0;
        word_cnt_d   = word_cnt_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;

        // Clear first so a drop in the same cycle still registers.
        if (clr_status) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end

        case (state_q)
            WAIT_SYNC: begin
                if (vsync_fall) begin
                    state_d    = FRAME;
                    row_d      = '0;
                    col_d      = '0;
                    byte_idx_d = 2'd0;
                    word_cnt_d = 16'd0;
                end
            end
            FRAME: begin
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    byte_idx_d   = 2'd0;
                    state_d      = WAIT_SYNC;
                end else if (!vsync) begin
                    if (href) begin
                        if (!(&col_q)) begin
                            col_d = col_q + 1'b1;
                        end
                        if (in_window) begin
                            shift_d    = shift_next;
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                if (buff_ready) begin
                                    data_d      = shift_next;
                                    buff_done_d = 1'b1;
                                    word_cnt_d  = word_cnt_q + 16'd1;
                                end else begin
                                    overflow_d = 1'b1;
                                    if (drop_cnt_d != 8'hFF) begin
                                        drop_cnt_d = drop_cnt_d + 8'd1;
                                    end
                                end
                            end
                        end
                    end else if (href_fall) begin
                        col_d      = '0;
                        byte_idx_d = 2'd0;
                        if (!(&row_q)) begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    assign data_buffer = data_q;
    assign buff_done   = buff_done_q;
    assign frame_done  = frame_done_q;
    assign word_cnt    = word_cnt_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_camera_pixel_packer.sv
// ============================================================================
// tb_camera_pixel_packer : randomized frames checked against a byte-group model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_camera_pixel_packer;

    localparam int HS = 2;
    localparam int HW = 16;
    localparam int VS = 1;
    localparam int VH = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        buff_ready = 1'b1;
    logic        clr_status = 1'b0;
    logic [31:0] data_buffer;
    logic        buff_done;
    logic        frame_done;
    logic [15:0] word_cnt;
    logic        overflow;
    logic [7:0]  drop_cnt;

    always #5 pclk = ~pclk;

    camera_pixel_packer #(
        .BUFF_LENGTH (32),
        .DATA_WIDTH  (8),
        .CNT_WIDTH   (12),
        .H_START     (HS),
        .H_WIDTH     (HW),
        .V_START     (VS),
        .V_HEIGHT    (VH)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .href        (href),
        .cam_data    (cam_data),
        .buff_ready  (buff_ready),
        .clr_status  (clr_status),
        .data_buffer (data_buffer),
        .buff_done   (buff_done),
        .frame_done  (frame_done),
        .word_cnt    (word_cnt),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Expected outputs; bytes of the current group are kept as a plain queue.
    logic [31:0] exp_data = 32'h0;
    logic        exp_bd = 1'b0;
    logic        exp_fd = 1'b0;
    logic [15:0] exp_wc = 16'h0;
    logic        exp_ovf = 1'b0;
    logic [7:0]  exp_drop = 8'h0;
    logic [7:0]  grp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("buff_done",   32'(buff_done),  32'(exp_bd));
        chk("frame_done",  32'(frame_done), 32'(exp_fd));
        chk("word_cnt",    32'(word_cnt),   32'(exp_wc));
        chk("overflow",    32'(overflow),   32'(exp_ovf));
        chk("drop_cnt",    32'(drop_cnt),   32'(exp_drop));
        chk("data_buffer", data_buffer,     exp_data);
    endtask

    task automatic model_reset();
        exp_data = 32'h0;
        exp_bd   = 1'b0;
        exp_fd   = 1'b0;
        exp_wc   = 16'h0;
        exp_ovf  = 1'b0;
        exp_drop = 8'h0;
        grp.delete();
    endtask

    // One pclk: drive, let the edge happen, update expectations, then compare.
    task automatic tick(input logic vs, input logic hr, input logic [7:0] d,
                        input logic rdy, input logic clr,
                        input bit cap, input bit fstart, input bit fend);
        logic [31:0] word;
        vsync      = vs;
        href       = hr;
        cam_data   = d;
        buff_ready = rdy;
        clr_status = clr;
        @(posedge pclk);
        exp_bd = 1'b0;
        exp_fd = fend;
        if (fstart) begin
            exp_wc = 16'h0;
            grp.delete();
        end
        if (clr) begin
            exp_ovf  = 1'b0;
            exp_drop = 8'h0;
        end
        if (cap) begin
            grp.push_back(d);
            if (grp.size() == 4) begin
                word = {grp[0], grp[1], grp[2], grp[3]};
                grp.delete();
                if (rdy) begin
                    exp_bd   = 1'b1;
                    exp_data = word;
                    exp_wc   = exp_wc + 16'd1;
                end else begin
                    exp_ovf = 1'b1;
                    if (exp_drop < 8'd255) exp_drop = exp_drop + 8'd1;
                end
            end
        end
        if (fend) grp.delete();
        #1;
        check_all();
    endtask

    // rdy_mode: 0 random, 1 always ready, 2 never ready.
    task automatic run_frame(input int nlines, input int fixed_len, input int rdy_mode,
                             input int clr_pct, input int mid_line, input int mid_byte,
                             input bit seq);
        int         len;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        bit         cap;
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 0);
        for (int r = 0; r < nlines; r++) begin
            repeat (1 + $urandom_range(0, 1)) begin
                clr = ($urandom_range(0, 99) < clr_pct);
                tick(1'b0, 1'b0, 8'($urandom), 1'($urandom), clr, 0, 0, 0);
            end
            len = (fixed_len > 0) ? fixed_len : $urandom_range(1, 24);
            for (int c = 0; c < len; c++) begin
                d   = seq ? 8'((c + 1) * 17) : 8'($urandom);
                rdy = (rdy_mode == 1) ? 1'b1 :
                      (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 99) < clr_pct);
                if (r == mid_line && c == mid_byte) begin
                    tick(1'b1, 1'b1, d, rdy, clr, 0, 0, 1);
                    tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
                    return;
                end
                cap = (r >= VS) && (r < VS + VH) && (c >= HS) && (c < HS + HW);
                tick(1'b0, 1'b1, d, rdy, clr, cap, 0, 0);
            end
            grp.delete();
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Bytes before any vsync fall must be ignored.
        repeat (20) tick(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 0, 0, 0);

        // Known bytes: row 1 columns 2..9 give 0x33445566 and 0x778899AA.
        run_frame(2, 10, 1, 0, -1, -1, 1);
        chk("basic_word_cnt", 32'(word_cnt), 32'd2);
        chk("basic_last_word", data_buffer, 32'h778899AA);

        // Partial lines and a vsync rise two bytes into a line.
        run_frame(3, 7, 1, 0, -1, -1, 1);
        run_frame(3, 12, 1, 0, 2, 2, 0);

        // Randomized frames with random readiness, clears and mid-line vsync.
        repeat (30) begin
            nl = $urandom_range(1, 7);
            if ($urandom_range(0, 3) == 0)
                run_frame(nl, 0, 0, 5, $urandom_range(0, nl - 1), $urandom_range(0, 20), 0);
            else
                run_frame(nl, 0, 0, 5, -1, -1, 0);
        end

        // Drop saturation: 20 frames x 16 dropped words each.
        repeat (20) run_frame(5, 18, 2, 0, -1, -1, 0);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0, 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);

        // Clear asserted every cycle while every word drops: drop wins.
        run_frame(2, 10, 2, 100, -1, -1, 0);

        // Asynchronous reset three bytes into a word.
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 0);
        tick(1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        for (int c = 0; c < 9; c++)
            tick(1'b0, 1'b1, 8'(8'hC0 + c), 1'b1, 1'b0, (c >= HS), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_data_buffer", data_buffer, 32'h0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_buff_done", 32'(buff_done), 32'd0);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        run_frame(2, 10, 1, 0, -1, -1, 0);
        run_frame(4, 0, 0, 0, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/camera_pixel_packer.md
Name: camera_pixel_packer

Overview:
Capture stage directly upstream of the camera-to-AXI bridge. Samples the DVP-style camera byte stream (vsync/href/8-bit data) in the pclk domain, crops it to a programmable window, and packs four consecutive bytes into one 32-bit word. Each word is presented as data_buffer with a single-cycle buff_done strobe for the bridge's dual-clock FIFO write port. Words the FIFO cannot accept are dropped and counted, because the camera cannot be stalled.

Parameters:
BUFF_LENGTH, 32, packed word width; fixed at 4 x DATA_WIDTH.
DATA_WIDTH, 8, camera byte width.
CNT_WIDTH, 12, width of the column and row counters.
H_START, 0, first captured byte column in each line (byte index, not pixel).
H_WIDTH, 1280, captured bytes per line; must be a multiple of 4.
V_START, 0, first captured line of the frame.
V_HEIGHT, 480, captured lines per frame.

Ports:
pclk  in  1  camera pixel clock; sole clock of the block.
rst_n  in  1  asynchronous, active-low reset.
vsync  in  1  frame sync; high = vertical blanking.
href  in  1  line valid; high = active bytes on cam_data.
cam_data  in  DATA_WIDTH  camera byte, sampled on pclk rising edge.
buff_ready  in  1  FIFO write-side ready (ready_a).
clr_status  in  1  one-cycle pulse; clears overflow and drop_cnt.
data_buffer  out  BUFF_LENGTH  packed word; first byte of the group in [31:24], last in [7:0].
buff_done  out  1  one-cycle write strobe; data_buffer is valid in the same cycle.
frame_done  out  1  one-cycle pulse at the end of a captured frame.
word_cnt  out  16  words accepted by the FIFO in the current or last frame.
overflow  out  1  sticky: a word was dropped.
drop_cnt  out  8  saturating count of dropped words.

Behaviour:
Reset:
- Asynchronous reset sets every output and internal register to 0.
- State returns to WAIT_SYNC.

Synchronisation:
- vsync is registered once (vsync_d); edges are detected from vsync and vsync_d.
- href is registered once (href_d); an href falling edge is href_d=1 and href=0.

State machine:
- WAIT_SYNC: ignore all bytes. On a vsync falling edge -> FRAME, with row=0, col=0, byte_idx=0, word_cnt=0.
- FRAME, vsync low: while href=1, each cycle samples one byte.
  - The byte is captured iff H_START <= col < H_START+H_WIDTH and V_START <= row < V_START+V_HEIGHT.
  - col increments every href=1 cycle and saturates at all-ones.
- FRAME, href falling edge:
  - col <= 0 and row <= row+1 (saturating).
  - A partial word (byte_idx != 0) is discarded, byte_idx <= 0, and the event is not counted.
- FRAME, vsync rising edge (frame end):
  - frame_done pulses for 1 cycle.
  - The partial word is discarded.
  - State -> WAIT_SYNC; word_cnt holds its value until the next frame start.
  - If vsync rises while href=1, the byte sampled in that cycle is not captured.

Packing:
- Captured bytes shift into a 32-bit shift register; byte_idx counts 0..3 (2-bit, wraps).
- When the 4th byte is captured in cycle N, data_buffer is loaded and buff_done=1 in cycle N+1, provided buff_ready=1 in cycle N.
- Latency from the 4th byte to the strobe is exactly 1 pclk.
- Back-to-back words are possible every 4 cycles.
- data_buffer holds its value between strobes.

Accepted word:
- word_cnt increments by 1 (wraps at 2^16).

Drop:
- If buff_ready=0 in cycle N, buff_done stays 0 and data_buffer is not updated.
- overflow <= 1, and drop_cnt increments, saturating at 255.

clr_status:
- Clears overflow and drop_cnt.
- If a drop occurs in the same cycle as clr_status, the drop wins: overflow=1, drop_cnt=1.

Crop window:
- H_START+H_WIDTH and V_START+V_HEIGHT are compared at CNT_WIDTH+1 bits, so no wrap-around.

Rows beyond the window: no words are emitted and no state change occurs until vsync rises.

Test Plan:
1. Basic packing: reset, vsync pulse, one line href=1 with bytes 0x11,0x22,...,0x88, buff_ready=1 -> two buff_done pulses, 1 cycle after the 4th and 8th bytes, with data_buffer=0x11223344 then 0x55667788; word_cnt=2.
2. Cropping: H_START=4, H_WIDTH=4, V_START=1, V_HEIGHT=1; three lines of 12 bytes 0x00..0x0B each -> exactly one word, 0x04050607, taken from line 1 only; frame_done at the vsync rise.
3. Overflow: buff_ready=0 for the 2nd of 3 words -> words 1 and 3 strobed; overflow=1, drop_cnt=1. clr_status pulse -> both 0. Repeat with 300 drops -> drop_cnt=255.
4. Partial line and mid-line vsync: a line of 6 bytes -> 1 word; the 2 trailing bytes are discarded and the next line's first word is aligned (byte_idx=0). vsync rises after 2 bytes of a line -> no strobe, frame_done=1, state WAIT_SYNC.
5. Bytes before first sync: cam_data streamed with href=1 before any vsync falling edge -> no buff_done; capture begins only after the vsync fall.
6. Reset mid-word: assert rst_n=0 asynchronously after 3 bytes -> all outputs 0 immediately; after release plus a new vsync fall, the first word contains only new bytes.
